perceptron_sequencer: RTL and testbench

Controller that loads a perceptron's weight and activation registers over the 4-bit nibble bus, then sequences a single shared multiply-accumulate unit across all elements. It returns the dot product through a valid/ready handshake. It sits between the pin-level nibble interface and the downstream result logic, replacing free-running register loads with a defined load → run → done schedule.

---
 rtl/perceptron_sequencer_pkg.sv | 23 ++
 rtl/perceptron_sequencer_if.sv | 32 +++
 rtl/perceptron_sequencer_nibble_shift_reg.sv | 40 ++++
 rtl/perceptron_sequencer.sv | 147 ++++++++++++++
 tb/tb_perceptron_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/perceptron_sequencer_pkg.sv
// perceptron_pkg: shared types and constants for the perceptron sequencer.
//   - state_t       : controller states (IDLE / RUN / DONE)
//   - SEL_*         : encoding of the 2-bit sel command input
//   - DEF_*         : default vector/element/accumulator sizes
package perceptron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] SEL_HOLD    = 2'b00;
    localparam logic [1:0] SEL_SHIFT_W = 2'b01;
    localparam logic [1:0] SEL_SHIFT_D = 2'b10;
    localparam logic [1:0] SEL_START   = 2'b11;

    localparam int DEF_N_ELEM   = 16;
    localparam int DEF_W_BITS   = 2;
    localparam int DEF_D_BITS   = 8;
    localparam int DEF_ACC_BITS = 16;

endpackage

// File: rtl/perceptron_sequencer_if.sv
// perceptron_sequencer_if: nibble load bus plus result handshake.
//   nib_in[3:0]   nibble shifted into the selected register
//   sel[1:0]      00 hold, 01 shift weights, 10 shift data, 11 start
//   clr[1:0]      bit0 clears weights, bit1 clears data
//   busy          high while the MAC is running
//   result        signed dot product (valid while result_valid)
//   result_valid  result available
//   result_ready  consumer accepts the result
// master: the side driving commands; slave: the sequencer.
interface perceptron_sequencer_if
    import perceptron_pkg::*;
#(
    parameter int ACC_BITS = DEF_ACC_BITS
);
    logic [3:0]          nib_in;
    logic [1:0]          sel;
    logic [1:0]          clr;
    logic                busy;
    logic [ACC_BITS-1:0] result;
    logic                result_valid;
    logic                result_ready;

    modport master (
        output nib_in, sel, clr, result_ready,
        input  busy, result, result_valid
    );

    modport slave (
        input  nib_in, sel, clr, result_ready,
        output busy, result, result_valid
    );
endinterface

// File: rtl/perceptron_sequencer_nibble_shift_reg.sv
// nibble_shift_reg: WIDTH-bit register loaded four bits at a time from the LSB
// end, so the first nibble shifted in ends up in the MSBs. Clear wins over
// shift. Asynchronous active-high reset to zero.
//   clk, rst   clock / async reset
//   shift_en   shift nib_in in this cycle
//   clr_en     zero the register this cycle (priority over shift_en)
//   nib_in     nibble to shift in
//   value      current register contents
module nibble_shift_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clr_en,
    input  logic [3:0]       nib_in,
    output logic [WIDTH-1:0] value
);
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr_en) begin
            value_d = '0;
        end else if (shift_en) begin
            value_d = {value_q[WIDTH-5:0], nib_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
endmodule

// File: rtl/perceptron_sequencer.sv
// perceptron_sequencer: loads weight and data registers over the nibble bus in
// IDLE, then steps one shared multiply-accumulate across all N_ELEM elements
// (one element per clock) and presents the dot product on a valid/ready
// handshake.
//   clk, rst   clock / asynchronous active-high reset
//   bus        perceptron_sequencer_if.slave (nibble bus + result handshake)
// Optional build macro PERCEPTRON_RELU_EN: result is latched as max(acc, 0);
// otherwise the raw signed accumulator is latched.
module perceptron_sequencer
    import perceptron_pkg::*;
#(
    parameter int N_ELEM   = DEF_N_ELEM,
    parameter int W_BITS   = DEF_W_BITS,
    parameter int D_BITS   = DEF_D_BITS,
    parameter int ACC_BITS = DEF_ACC_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    perceptron_sequencer_if.slave  bus
);
    localparam int IDX_BITS = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int W_REG    = N_ELEM * W_BITS;
    localparam int D_REG    = N_ELEM * D_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_ELEM - 1);

    state_t                      state_q, state_d;
    logic [IDX_BITS-1:0]         idx_q, idx_d;
    logic signed [ACC_BITS-1:0]  acc_q, acc_d;
    logic signed [ACC_BITS-1:0]  result_q, result_d;
    logic                        busy_q, busy_d;
    logic                        valid_q, valid_d;

    logic                        w_shift, w_clr, d_shift, d_clr;
    logic [W_REG-1:0]            w_value;
    logic [D_REG-1:0]            d_value;

    nibble_shift_reg #(.WIDTH(W_REG)) u_weights (
        .clk      (clk),
        .rst      (rst),
        .shift_en (w_shift),
        .clr_en   (w_clr),
        .nib_in   (bus.nib_in),
        .value    (w_value)
    );

    nibble_shift_reg #(.WIDTH(D_REG)) u_data (
        .clk      (clk),
        .rst      (rst),
        .shift_en (d_shift),
        .clr_en   (d_clr),
        .nib_in   (bus.nib_in),
        .value    (d_value)
    );

    // Current element: signed weight times zero-extended data, widened to the
    // accumulator with sign extension.
    logic signed [W_BITS-1:0]        w_elem;
    logic [D_BITS-1:0]               d_elem;
    logic signed [W_BITS+D_BITS:0]   prod;
    logic signed [ACC_BITS-1:0]      prod_ext;
    logic signed [ACC_BITS-1:0]      acc_sum;
    logic signed [ACC_BITS-1:0]      act_val;

    always_comb begin
        w_elem   = w_value[idx_q*W_BITS +: W_BITS];
        d_elem   = d_value[idx_q*D_BITS +: D_BITS];
        prod     = w_elem * $signed({1'b0, d_elem});
        prod_ext = ACC_BITS'(prod);
        acc_sum  = acc_q + prod_ext;
`ifdef PERCEPTRON_RELU_EN
        act_val  = acc_sum[ACC_BITS-1] ? '0 : acc_sum;
`else
        act_val  = acc_sum;
`endif
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        w_shift  = 1'b0;
        w_clr    = 1'b0;
        d_shift  = 1'b0;
        d_clr    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_clr   = bus.clr[0];
                d_clr   = bus.clr[1];
                w_shift = (bus.sel == SEL_SHIFT_W);
                d_shift = (bus.sel == SEL_SHIFT_D);
                if (bus.sel == SEL_START) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                acc_d = acc_sum;
                idx_d = idx_q + IDX_BITS'(1);
                if (idx_q == LAST_IDX) begin
                    state_d  = ST_DONE;
                    busy_d   = 1'b0;
                    valid_d  = 1'b1;
                    result_d = act_val;
                end
            end
            ST_DONE: begin
                if (bus.result_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
endmodule

// File: tb/tb_perceptron_sequencer.sv
// Self-checking bench for perceptron_sequencer: directed scenarios with
// hand-computed results, then randomized load/run/handshake traffic checked
// every cycle against a behavioural model of the block.
module tb_perceptron_sequencer;
    import perceptron_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    perceptron_sequencer_if #(.ACC_BITS(16)) bus ();

    perceptron_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [15:0] dot(input logic [31:0] w, input logic [127:0] d);
        int s;
        int we;
        int de;
        logic [31:0] s_bits;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            we = $signed(w[2*i +: 2]);
            de = int'(d[8*i +: 8]);
            s  = s + we * de;
        end
        s_bits = s;
        return s_bits[15:0];
    endfunction

    function automatic logic [15:0] act_fn(input logic [15:0] a);
`ifdef PERCEPTRON_RELU_EN
        return a[15] ? 16'h0000 : a;
`else
        return a;
`endif
    endfunction

    logic [31:0]  m_w;
    logic [127:0] m_d;
    logic [15:0]  m_dot;
    logic [15:0]  m_result;
    logic         m_busy;
    logic         m_valid;
    int           m_mode;   // 0 loading, 1 computing, 2 holding result
    int           m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_w = '0; m_d = '0; m_dot = '0; m_result = '0;
            m_busy = 1'b0; m_valid = 1'b0; m_mode = 0; m_cnt = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (bus.clr[0]) m_w = '0;
                    else if (bus.sel == SEL_SHIFT_W) m_w = {m_w[27:0], bus.nib_in};
                    if (bus.clr[1]) m_d = '0;
                    else if (bus.sel == SEL_SHIFT_D) m_d = {m_d[123:0], bus.nib_in};
                    if (bus.sel == SEL_START) begin
                        m_dot  = dot(m_w, m_d);
                        m_mode = 1;
                        m_cnt  = 0;
                        m_busy = 1'b1;
                    end
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == 16) begin
                        m_mode   = 2;
                        m_busy   = 1'b0;
                        m_valid  = 1'b1;
                        m_result = act_fn(m_dot);
                    end
                end
                default: begin
                    if (bus.result_ready) begin
                        m_mode  = 0;
                        m_valid = 1'b0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_busy",   {31'b0, bus.busy},         {31'b0, m_busy});
            check("cyc_valid",  {31'b0, bus.result_valid}, {31'b0, m_valid});
            check("cyc_result", {16'b0, bus.result},       {16'b0, m_result});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [31:0] v);
        for (int k = 0; k < 8; k++) begin
            bus.sel    = SEL_SHIFT_W;
            bus.nib_in = v[31-4*k -: 4];
            step();
        end
        bus.sel = SEL_HOLD;
    endtask

    task automatic load_d(input logic [127:0] v);
        for (int k = 0; k < 32; k++) begin
            bus.sel    = SEL_SHIFT_D;
            bus.nib_in = v[127-4*k -: 4];
            step();
        end
        bus.sel = SEL_HOLD;
    endtask

    task automatic run_job(input bit noisy, output int busy_cycles, output logic [15:0] res);
        bit got;
        got         = 1'b0;
        busy_cycles = 0;
        bus.sel     = SEL_START;
        bus.clr     = 2'b00;
        step();
        bus.sel     = SEL_HOLD;
        for (int n = 0; n < 64; n++) begin
            if (bus.result_valid) begin
                got = 1'b1;
                break;
            end
            if (bus.busy) busy_cycles++;
            if (noisy) begin
                bus.sel    = 2'($urandom_range(0, 3));
                bus.clr    = 2'($urandom_range(0, 3));
                bus.nib_in = 4'($urandom);
            end
            step();
        end
        bus.sel = SEL_HOLD;
        bus.clr = 2'b00;
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL job_timeout: result_valid got 0 expected 1 within 64 cycles");
        end
        res = bus.result;
    endtask

    task automatic accept();
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
        check("valid_after_accept", {31'b0, bus.result_valid}, 32'd0);
    endtask

    // ---------------- test sequence ----------------
    int          bc;
    logic [15:0] res;
    logic [15:0] neg_exp;

    initial begin
`ifdef PERCEPTRON_RELU_EN
        neg_exp = 16'h0000;
`else
        neg_exp = 16'hE020;
`endif
        bus.nib_in = '0;
        bus.sel = SEL_HOLD;
        bus.clr = 2'b00;
        bus.result_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   {31'b0, bus.busy},         32'd0);
        check("reset_valid",  {31'b0, bus.result_valid}, 32'd0);
        check("reset_result", {16'b0, bus.result},       32'd0);
        rst = 1'b0;
        step();

        // positive dot product
        load_w(32'h5555_5555);
        load_d({16{8'h01}});
        run_job(1'b0, bc, res);
        check("pos_result", {16'b0, res}, 32'h0010);
        check("pos_busy_cycles", bc, 32'd16);

        // backpressure: DONE held stable while not ready
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_valid",  {31'b0, bus.result_valid}, 32'd1);
            check("bp_result", {16'b0, bus.result},       32'h0010);
        end
        accept();
        run_job(1'b0, bc, res);
        check("restart_result", {16'b0, res}, 32'h0010);
        accept();

        // negative dot product
        load_w(32'hAAAA_AAAA);
        load_d({16{8'hFF}});
        run_job(1'b0, bc, res);
        check("neg_result", {16'b0, res}, {16'b0, neg_exp});
        accept();

        // commands during RUN are ignored
        run_job(1'b1, bc, res);
        check("noisy_result", {16'b0, res}, {16'b0, neg_exp});
        accept();

        // clear priority over shift on the same register
        bus.clr = 2'b01; bus.sel = SEL_SHIFT_W; bus.nib_in = 4'hF;
        step();
        bus.clr = 2'b00; bus.sel = SEL_HOLD;
        run_job(1'b0, bc, res);
        check("clr_w_result", {16'b0, res}, 32'h0000);
        accept();
        load_w(32'h5555_5555);
        run_job(1'b0, bc, res);
        check("data_kept_result", {16'b0, res}, 32'h0FF0);
        accept();

        // asynchronous reset in the middle of a run
        bus.sel = SEL_START;
        step();
        bus.sel = SEL_HOLD;
        repeat (7) step();
        check("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_busy",   {31'b0, bus.busy},         32'd0);
        check("midrst_valid",  {31'b0, bus.result_valid}, 32'd0);
        check("midrst_result", {16'b0, bus.result},       32'd0);
        step();
        rst = 1'b0;
        step();
        run_job(1'b0, bc, res);
        check("post_rst_result", {16'b0, res}, 32'h0000);
        accept();

        // randomized traffic
        for (int j = 0; j < 30; j++) begin
            int nl;
            nl = $urandom_range(1, 48);
            for (int k = 0; k < nl; k++) begin
                bus.sel    = 2'($urandom_range(0, 2));
                bus.clr    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                bus.nib_in = 4'($urandom);
                step();
            end
            bus.sel = SEL_HOLD;
            bus.clr = 2'b00;
            bus.result_ready = $urandom_range(0, 1) == 1;
            run_job($urandom_range(0, 1) == 1, bc, res);
            check("rand_result", {16'b0, res}, {16'b0, act_fn(dot(m_w, m_d))});
            check("rand_busy_cycles", bc, 32'd16);
            if (!bus.result_ready) begin
                repeat ($urandom_range(0, 3)) step();
            end
            accept();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
